data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised, handshaked successor to the single-cycle data memory used by the RV32I core's load/store stage. It accepts one request at a time over a req/ready handshake and inserts a configurable number of wait states. Stores use per-lane byte enables. Loads are sign- or zero-extended. Misaligned, out-of-range and invalid-size accesses are flagged as errors rather than silently wrapped. It sits between the LSU and the memory array, and the LSU stalls on ready_o/rsp_valid_o.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).
ADDR_WIDTH, 32, width of the byte address input.
WAIT_STATES, 1, extra cycles between acceptance and access (0..15).

Ports:
clk_i  input  1  clock, rising edge.
reset_ni  input  1  asynchronous, active-low reset.
req_i  input  1  request valid.
ready_o  output  1  controller can accept a request this cycle.
we_i  input  1  1 = store, 0 = load.
req_size_i  input  2  00 = byte, 01 = half, 10 = word, 11 = invalid.
unsigned_i  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
addr_i  input  ADDR_WIDTH  byte address.
data_i  input  32  store data, right-aligned.
rsp_valid_o  output  1  one-cycle response strobe.
data_o  output  32  formatted load data; 0 for stores and errors.
err_o  output  1  access error, valid with rsp_valid_o.

Behaviour:
- Clock and reset: one clock domain, clk_i. reset_ni is asynchronous and active-low.
- Reset state: state = IDLE, rsp_valid_o = 0, data_o = 0, err_o = 0, wait counter = 0. Array contents are not reset.
- ready_o is 1 exactly when state == IDLE, including while reset is held. No request is accepted on an edge where reset_ni is low.
- IDLE: on an edge with req_i & ready_o, latch we, size, unsigned, addr and data, load the counter with WAIT_STATES, and go to BUSY.
- BUSY: while the counter is nonzero, decrement it each edge.
  - On the edge where the counter == 0, perform the access, register data_o and err_o, set rsp_valid_o = 1, and go to RESP.
- RESP: lasts exactly one cycle, with no backpressure. On the next edge, rsp_valid_o = 0 and the state returns to IDLE. data_o and err_o hold until the next response.
- Latency: rsp_valid_o rises WAIT_STATES+1 edges after the accept edge. Throughput is one request per WAIT_STATES+3 cycles.
- Address and lane mapping:
  - word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0]; little-endian.
- Error conditions (any one sets err_o = 1 and forces data_o = 0; stores write nothing):
  - size 11;
  - half-word access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr >= DEPTH_WORDS*4, with the unsigned compare done at the full ADDR_WIDTH.
- Stores:
  - byte: data_i[7:0] written to the lane addr[1:0]; other bytes unchanged.
  - half: data_i[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 bytes written.
  - data_o = 0 for every store.
- Loads: extract the selected byte or half and extend to 32 bits per unsigned_i. Word loads are returned unchanged.
- Inputs other than req_i are sampled only on the accept edge. Changes during BUSY or RESP have no effect.
- Reset mid-operation: reset_ni falling in BUSY or RESP returns the state to IDLE immediately and clears the outputs.
  - A pending store is dropped if reset asserts before its commit edge.
  - A store already committed is kept.
- req_i held high continuously: the next request is accepted on the first edge in IDLE after RESP.

Test Plan:
1. Word store 0xAABBCCDD at 0x10, then word load at 0x10 with WAIT_STATES=1 -> rsp_valid_o high exactly 2 edges after each accept; load returns data_o=0xAABBCCDD, err_o=0. ready_o is low in BUSY and RESP.
2. Byte loads at 0x10..0x13 with unsigned_i=0 -> 0xFFFFFFDD, 0xFFFFFFCC, 0xFFFFFFBB, 0xFFFFFFAA. With unsigned_i=1 -> 0x000000DD, 0x000000CC, 0x000000BB, 0x000000AA.
3. Byte store 0xFF at 0x11, then word load at 0x10 -> 0xAABBFFDD. Half store 0x1234 at 0x12, then word load -> 0x1234FFDD. Half load at 0x12 signed -> 0x00001234; half load at 0x10 signed -> 0xFFFFFFDD.
4. Error cases, each -> err_o=1, data_o=0, and a following word load of 0x10 still returns 0x1234FFDD:
   - half store at 0x11;
   - word load at 0x12;
   - size 11 at 0x10;
   - word store at 0x400 with DEPTH_WORDS=256.
5. Word store 0x00000000 to 0x10 accepted with WAIT_STATES=3; pulse reset_ni low during BUSY -> outputs 0 immediately and ready_o=1 after release; word load at 0x10 returns 0x1234FFDD.
6. Parameter sweep with WAIT_STATES in {0, 3} and req_i held high for 4 back-to-back loads -> responses spaced WAIT_STATES+3 cycles apart, each with the correct data and no request lost.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Handshaked data memory for the RV32I load/store stage: one request at a time,
// configurable wait states, byte-enable stores, sign/zero-extended loads, error flagging.
//
// state | meaning
// IDLE  | ready_o high, waiting for req_i
// BUSY  | request latched, wait counter running down to the access edge
// RESP  | rsp_valid_o high for exactly one cycle
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           data_o,
  output logic                  err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [3:0]            r_wait_cnt;
  logic                  r_we;
  logic                  r_uns;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic [31:0]           r_mem [DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_commit;
  logic                  w_misalign;
  logic                  w_oob;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_al;
  logic [31:0]           w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_i) w_state_nxt = S_BUSY;
      S_BUSY: if (r_wait_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    ready_o  = 1'b0;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: ready_o = 1'b1;
      S_BUSY: w_access = (r_wait_cnt == 4'd0);
      default: begin
        ready_o  = 1'b0;
        w_access = 1'b0;
      end
    endcase
  end

  assign w_accept = req_i & ready_o;

  // Error decode on the latched request; the range test needs no wide constant because depth is a power of two
  assign w_lane     = r_addr[1:0];
  assign w_idx      = r_addr[IDX_W+1:2];
  assign w_oob      = (r_addr >> (IDX_W + 2)) != '0;
  assign w_misalign = ((r_size == 2'd1) && r_addr[0]) ||
                      ((r_size == 2'd2) && (r_addr[1:0] != 2'd0));
  assign w_err      = (r_size == 2'd3) || w_misalign || w_oob;
  assign w_commit   = w_access && r_we && !w_err;

  always_comb begin
    w_be       = 4'b0000;
    w_wdata_al = r_wdata;
    case (r_size)
      2'd0: begin
        w_be       = 4'b0001 << w_lane;
        w_wdata_al = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_al = {2{r_wdata[15:0]}};
      end
      2'd2: begin
        w_be       = 4'b1111;
        w_wdata_al = r_wdata;
      end
      default: begin
        w_be       = 4'b0000;
        w_wdata_al = r_wdata;
      end
    endcase
  end

  // Load formatting
  always_comb begin
    w_rword = r_mem[w_idx];
    w_byte  = w_rword[7:0];
    case (w_lane)
      2'd0: w_byte = w_rword[7:0];
      2'd1: w_byte = w_rword[15:8];
      2'd2: w_byte = w_rword[23:16];
      2'd3: w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
    w_half = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
    case (r_size)
      2'd0:    w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wait_cnt  <= 4'd0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      rsp_valid_o <= 1'b0;
      data_o      <= 32'd0;
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= w_access;
      if (w_accept) begin
        r_we       <= we_i;
        r_uns      <= unsigned_i;
        r_size     <= req_size_i;
        r_addr     <= addr_i;
        r_wdata    <= data_i;
        r_wait_cnt <= 4'(WAIT_STATES);
      end else if ((r_state == S_BUSY) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_access) begin
        err_o  <= w_err;
        data_o <= (w_err || r_we) ? 32'd0 : w_load;
      end
    end
  end

  // Array contents survive reset; a store in flight is lost because reset forces IDLE before its commit edge
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (WAIT_STATES 1, 0, 3) checked against
// directed vectors, a byte-array reference model under random traffic, and reset/burst sequences.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req  [3];
  logic        we   [3];
  logic        uns  [3];
  logic [1:0]  sz   [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic        err  [3];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mm [3][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_ctrl #(
      .DEPTH_WORDS (256),
      .ADDR_WIDTH  (32),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .req_i       (req[g]),
      .ready_o     (rdy[g]),
      .we_i        (we[g]),
      .req_size_i  (sz[g]),
      .unsigned_i  (uns[g]),
      .addr_i      (addr[g]),
      .data_i      (wdat[g]),
      .rsp_valid_o (rv[g]),
      .data_o      (dout[g]),
      .err_o       (err[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference model: memory as a flat byte array, rules applied directly to byte addresses
  task automatic ref_access(input int k, input logic w, input logic [1:0] s, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] d, output logic e);
    int nb;
    int base;
    logic [31:0] v;
    nb = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    e  = (s == 2'd3) || ((a % nb) != 0) || (a >= 32'd1024);
    d  = 32'd0;
    if (!e) begin
      base = int'(a);
      if (w) begin
        for (int i = 0; i < nb; i++) mm[k][base + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[k][base + i];
        if (!u && nb < 4 && v[8*nb - 1]) begin
          for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
        end
        d = v;
      end
    end
  endtask

  // One complete transaction; inputs are scrambled after the accept edge
  task automatic do_txn(input int k, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic e);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chkb("ready_idle", rdy[k], 1'b1);
    req[k] = 1'b1; we[k] = w; sz[k] = s; uns[k] = u; addr[k] = a; wdat[k] = d;
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = 1'($urandom); sz[k] = 2'($urandom); uns[k] = 1'($urandom);
    addr[k] = $urandom; wdat[k] = $urandom;
    chkb("ready_busy", rdy[k], 1'b0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rv[k] && n < 50);
    chk("latency", 32'(n), 32'(ws(k) + 1));
    chkb("ready_resp", rdy[k], 1'b0);
    q = dout[k];
    e = err[k];
    @(posedge clk); #1;
    chkb("rsp_one_cycle", rv[k], 1'b0);
  endtask

  task automatic burst(input int k);
    logic [31:0] al [4];
    logic [31:0] ex [4];
    logic ee, r;
    int acc, nrsp, last, cyc;
    for (int i = 0; i < 4; i++) begin
      al[i] = 32'h20 + 32'(4*i);
      ref_access(k, 1'b0, 2'd2, 1'b0, al[i], 32'd0, ex[i], ee);
    end
    @(negedge clk);
    acc = 0; nrsp = 0; last = 0;
    req[k] = 1'b1; we[k] = 1'b0; sz[k] = 2'd2; uns[k] = 1'b0; addr[k] = al[0];
    for (cyc = 1; cyc <= 60 && nrsp < 4; cyc++) begin
      r = rdy[k];
      @(posedge clk); #1;
      if (r && req[k]) begin
        acc++;
        if (acc < 4) addr[k] = al[acc];
        else req[k] = 1'b0;
      end
      if (rv[k]) begin
        chk("burst_data", dout[k], ex[nrsp]);
        chkb("burst_err", err[k], 1'b0);
        if (nrsp > 0) chk("burst_spacing", 32'(cyc - last), 32'(ws(k) + 3));
        last = cyc;
        nrsp++;
      end
    end
    req[k] = 1'b0;
    chk("burst_responses", 32'(nrsp), 32'd4);
    chk("burst_accepts", 32'(acc), 32'd4);
  endtask

  typedef struct packed {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    vec_t v;
    v.w = w; v.s = s; v.u = u; v.a = a; v.wd = wd; v.exp_d = exp_d; v.exp_e = exp_e;
    return v;
  endfunction

  initial begin
    logic [31:0] q, md;
    logic        e, me;
    int          r;
    logic [31:0] a;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; uns[k] = 1'b0; sz[k] = 2'd0; addr[k] = 32'd0; wdat[k] = 32'd0;
    end
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chkb("reset_ready", rdy[k], 1'b1);
      chkb("reset_rsp_valid", rv[k], 1'b0);
      chk("reset_data", dout[k], 32'd0);
      chkb("reset_err", err[k], 1'b0);
    end
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      do_txn(0, 1'b1, 2'd2, 1'b0, 32'(4*i), 32'hC0DE0000 | 32'(i), q, e);
      ref_access(0, 1'b1, 2'd2, 1'b0, 32'(4*i), 32'hC0DE0000 | 32'(i), md, me);
    end

    tbl.push_back(mk(1, 2'd2, 0, 32'h10,  32'hAABBCCDD, 32'h00000000, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'hAABBCCDD, 0));
    tbl.push_back(mk(0, 2'd0, 0, 32'h10,  32'h0,        32'hFFFFFFDD, 0));
    tbl.push_back(mk(0, 2'd0, 0, 32'h11,  32'h0,        32'hFFFFFFCC, 0));
    tbl.push_back(mk(0, 2'd0, 0, 32'h12,  32'h0,        32'hFFFFFFBB, 0));
    tbl.push_back(mk(0, 2'd0, 0, 32'h13,  32'h0,        32'hFFFFFFAA, 0));
    tbl.push_back(mk(0, 2'd0, 1, 32'h10,  32'h0,        32'h000000DD, 0));
    tbl.push_back(mk(0, 2'd0, 1, 32'h11,  32'h0,        32'h000000CC, 0));
    tbl.push_back(mk(0, 2'd0, 1, 32'h12,  32'h0,        32'h000000BB, 0));
    tbl.push_back(mk(0, 2'd0, 1, 32'h13,  32'h0,        32'h000000AA, 0));
    tbl.push_back(mk(1, 2'd0, 0, 32'h11,  32'h123456FF, 32'h00000000, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'hAABBFFDD, 0));
    tbl.push_back(mk(1, 2'd1, 0, 32'h12,  32'hABCD1234, 32'h00000000, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'h1234FFDD, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h12,  32'h0,        32'h00001234, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h10,  32'h0,        32'hFFFFFFDD, 0));
    tbl.push_back(mk(1, 2'd1, 0, 32'h11,  32'h00005555, 32'h00000000, 1));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'h1234FFDD, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h12,  32'h0,        32'h00000000, 1));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'h1234FFDD, 0));
    tbl.push_back(mk(1, 2'd3, 0, 32'h10,  32'h77777777, 32'h00000000, 1));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'h1234FFDD, 0));
    tbl.push_back(mk(1, 2'd2, 0, 32'h400, 32'hDEADBEEF, 32'h00000000, 1));
    tbl.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        32'h1234FFDD, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h0,   32'h0,        32'hC0DE0000, 0));
    tbl.push_back(mk(1, 2'd1, 0, 32'h1A,  32'h00008001, 32'h00000000, 0));
    tbl.push_back(mk(0, 2'd1, 1, 32'h1A,  32'h0,        32'h00008001, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h1A,  32'h0,        32'hFFFF8001, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h3FC, 32'h0,        32'hC0DE00FF, 0));
    tbl.push_back(mk(0, 2'd0, 0, 32'hFFFFFFFC, 32'h0,   32'h00000000, 1));

    foreach (tbl[i]) begin
      do_txn(0, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].wd, q, e);
      ref_access(0, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].wd, md, me);
      chk($sformatf("vec%0d_data", i), q, tbl[i].exp_d);
      chkb($sformatf("vec%0d_err", i), e, tbl[i].exp_e);
    end

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 1023));
      we[0] = 1'($urandom); sz[0] = 2'($urandom); uns[0] = 1'($urandom); wdat[0] = $urandom;
      ref_access(0, we[0], sz[0], uns[0], a, wdat[0], md, me);
      do_txn(0, we[0], sz[0], uns[0], a, wdat[0], q, e);
      chk("rand_data", q, md);
      chkb("rand_err", e, me);
    end

    do_txn(2, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234FFDD, q, e);
    ref_access(2, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234FFDD, md, me);
    do_txn(2, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, q, e);
    chk("rst_pre_load", q, 32'h1234FFDD);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; sz[2] = 2'd2; uns[2] = 1'b0; addr[2] = 32'h10; wdat[2] = 32'h0;
    @(posedge clk); #1;
    req[2] = 1'b0;
    chkb("rst_busy_ready", rdy[2], 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chkb("rst_mid_ready", rdy[2], 1'b1);
    chkb("rst_mid_rsp_valid", rv[2], 1'b0);
    chk("rst_mid_data", dout[2], 32'd0);
    chkb("rst_mid_err", err[2], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chkb("rst_after_ready", rdy[2], 1'b1);
    chkb("rst_after_no_rsp", rv[2], 1'b0);
    do_txn(2, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, q, e);
    chk("rst_dropped_store", q, 32'h1234FFDD);
    chkb("rst_dropped_err", e, 1'b0);

    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        a = 32'h20 + 32'(4*i);
        do_txn(k, 1'b1, 2'd2, 1'b0, a, 32'h600D0000 + 32'(i*273) + 32'(k), q, e);
        ref_access(k, 1'b1, 2'd2, 1'b0, a, 32'h600D0000 + 32'(i*273) + 32'(k), md, me);
      end
      burst(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
